// File: rtl/uart_char_rx.sv
// 8N1 serial receiver with a one-entry valid/ready output register.
// Also flags ASCII lowercase bytes for the downstream case-conversion stage.
module uart_char_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] char_o,
  output logic       is_lower_o,
  output logic       char_valid_o,
  input  logic       char_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             sync1;
  logic             rx_s;
  logic             rx_prev;

  // Two-flop synchroniser plus a history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_i;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      char_o       <= '0;
      is_lower_o   <= 1'b0;
      char_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (char_valid_o && char_ready_i) begin
        char_valid_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_s) begin
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= IDLE;
            if (!rx_s) begin
              frame_err_o <= 1'b1;
            end else if (!char_valid_o || char_ready_i) begin
              // Load wins over the concurrent transfer clear above.
              char_o       <= shift;
              is_lower_o   <= (shift >= 8'h61) && (shift <= 8'h7A);
              char_valid_o <= 1'b1;
            end else begin
              overrun_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_char_rx.sv
// Scoreboard bench for uart_char_rx: expected bytes queued at send time,
// popped and compared on each valid/ready transfer.
module tb_uart_char_rx;

  localparam int unsigned CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] char_o;
  logic       is_lower_o;
  logic       char_valid_o;
  logic       char_ready_i;
  logic       frame_err_o;
  logic       overrun_o;

  uart_char_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_i),
    .char_o       (char_o),
    .is_lower_o   (is_lower_o),
    .char_valid_o (char_valid_o),
    .char_ready_i (char_ready_i),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ferr  = 0;
  int n_ovr   = 0;
  int n_vcyc  = 0;
  int b_ferr, b_ovr, b_vcyc;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] b);
    logic low;
    low = (b >= 8'h61) && (b <= 8'h7A);
    return {low, b};
  endfunction

  // Inputs change 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      tick(CPB);
    end
    rx_i = stop;
    tick(CPB);
    rx_i = 1'b1;
  endtask

  task automatic snap();
    b_ferr = n_ferr;
    b_ovr  = n_ovr;
    b_vcyc = n_vcyc;
  endtask

  // Monitor on the falling edge: inputs are stable, outputs settled.
  logic       pv, pr;
  logic [7:0] pc;
  logic       pl;
  initial begin
    pv = 1'b0; pr = 1'b0; pc = '0; pl = 1'b0;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (pv && !pr) begin
        check("hold_valid", 32'(char_valid_o), 32'd1);
        check("stable_char", 32'(char_o), 32'(pc));
        check("stable_lower", 32'(is_lower_o), 32'(pl));
      end
      if (char_valid_o && char_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 32'(char_o), 32'hFFFF);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("char", 32'(char_o), 32'(e[7:0]));
          check("is_lower", 32'(is_lower_o), 32'(e[8]));
        end
      end
      if (frame_err_o) n_ferr++;
      if (overrun_o)   n_ovr++;
      if (char_valid_o) n_vcyc++;
    end
    pv = rst_n && char_valid_o;
    pr = char_ready_i;
    pc = char_o;
    pl = is_lower_o;
  end

  initial begin
    rst_n = 1'b0;
    rx_i = 1'b1;
    char_ready_i = 1'b0;
    tick(3);
    check("rst_char", 32'(char_o), 32'd0);
    check("rst_valid", 32'(char_valid_o), 32'd0);
    check("rst_flags", 32'({is_lower_o, frame_err_o, overrun_o}), 32'd0);
    rst_n = 1'b1;
    tick(5);

    // 1: single 'a' with ready high
    char_ready_i = 1'b1;
    snap();
    exp_q.push_back(model(8'h61));
    send(8'h61, 1'b1);
    tick(6);
    check("t1_valid_cycles", 32'(n_vcyc - b_vcyc), 32'd1);
    check("t1_ferr", 32'(n_ferr - b_ferr), 32'd0);
    check("t1_ovr", 32'(n_ovr - b_ovr), 32'd0);
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // 2: back-to-back frames
    exp_q.push_back(model(8'h41));
    exp_q.push_back(model(8'h7B));
    send(8'h41, 1'b1);
    send(8'h7B, 1'b1);
    tick(6);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // 3: overrun while the register holds 0x7A
    char_ready_i = 1'b0;
    snap();
    exp_q.push_back(model(8'h7A));
    send(8'h7A, 1'b1);
    send(8'h62, 1'b1);
    tick(6);
    check("t3_ovr", 32'(n_ovr - b_ovr), 32'd1);
    check("t3_held_char", 32'(char_o), 32'h7A);
    check("t3_held_valid", 32'(char_valid_o), 32'd1);
    char_ready_i = 1'b1;
    tick(1);
    char_ready_i = 1'b0;
    tick(3);
    check("t3_drained", 32'(exp_q.size()), 32'd0);
    check("t3_valid_low", 32'(char_valid_o), 32'd0);

    // 4: stop bit low, then a good frame
    char_ready_i = 1'b1;
    snap();
    send(8'h55, 1'b0);
    tick(6);
    check("t4_ferr", 32'(n_ferr - b_ferr), 32'd1);
    check("t4_no_valid", 32'(n_vcyc - b_vcyc), 32'd0);
    exp_q.push_back(model(8'h63));
    send(8'h63, 1'b1);
    tick(6);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // 5: 4-cycle glitch
    snap();
    rx_i = 1'b0;
    tick(4);
    rx_i = 1'b1;
    tick(40);
    check("t5_pulses", 32'((n_vcyc - b_vcyc) + (n_ferr - b_ferr) + (n_ovr - b_ovr)), 32'd0);

    // 6: reset mid-data of 0x6D, then 0x6E
    rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_i = 1'(8'h6D >> i);
      tick(CPB);
    end
    rst_n = 1'b0;
    rx_i = 1'b1;
    tick(2);
    check("t6_rst_outputs", 32'({char_o, is_lower_o, char_valid_o, frame_err_o, overrun_o}), 32'd0);
    rst_n = 1'b1;
    tick(20);
    snap();
    exp_q.push_back(model(8'h6E));
    send(8'h6E, 1'b1);
    tick(6);
    check("t6_drained", 32'(exp_q.size()), 32'd0);
    check("t6_valid_cycles", 32'(n_vcyc - b_vcyc), 32'd1);

    // 7: ready asserted exactly on the stop-sample cycle with a full register
    char_ready_i = 1'b0;
    exp_q.push_back(model(8'h70));
    send(8'h70, 1'b1);
    tick(4);
    snap();
    exp_q.push_back(model(8'h71));
    fork
      send(8'h71, 1'b1);
      begin
        tick(154);
        char_ready_i = 1'b1;
        tick(1);
        char_ready_i = 1'b0;
      end
    join
    tick(4);
    check("t7_no_ovr", 32'(n_ovr - b_ovr), 32'd0);
    check("t7_new_char", 32'(char_o), 32'h71);
    check("t7_new_valid", 32'(char_valid_o), 32'd1);
    check("t7_one_left", 32'(exp_q.size()), 32'd1);
    char_ready_i = 1'b1;
    tick(4);
    check("t7_drained", 32'(exp_q.size()), 32'd0);
    check("end_ferr_total", 32'(n_ferr), 32'd1);
    check("end_ovr_total", 32'(n_ovr), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
